fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of an `async_fifo` instance among N requesters on the FIFO's write-clock domain. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst and drives the FIFO's `wr_en`/`wr_data`. It never writes while `full` is high, so the FIFO's overflow check can never fire.

---
 rtl/fifo_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest requester vector the helper accepts; narrower vectors are zero-extended.
    localparam int MAX_REQ = 8;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first eligible bit at or above rr_ptr, with wrap-around.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  pick
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && eligible[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among N valid/ready requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    output logic [N-1:0]   req_ready,
    input  logic [N-1:0]   req_mask,
    input  logic           fifo_full,
    output logic           fifo_wr_en,
    output logic [W-1:0]   fifo_wr_data,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    arb_state_t    state, state_next;
    logic [N-1:0]  grant_next;
    logic [PW-1:0] rr_ptr, rr_ptr_next;
    logic [BW-1:0] beat_cnt, beat_cnt_next;

    logic [N-1:0]  eligible;
    logic [N-1:0]  pick;
    logic [PW-1:0] owner_idx;
    logic          owner_valid;
    logic          beat;
    logic          last_beat;
    logic          release_grant;
    logic [W-1:0]  owner_data;

    assign eligible = req_valid & req_mask;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .pick     (pick)
    );

    // Owner decode is shared by the datapath mux, the beat test and the pointer update.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                owner_data = req_data[i*W +: W];
            end
        end
    end

    assign owner_idx     = PW'(onehot_to_idx(MAX_REQ'(grant)));
    assign owner_valid   = |(req_valid & grant);
    assign beat          = (state == GRANT) && owner_valid && !fifo_full;
    assign last_beat     = (beat_cnt == BW'(MAX_BURST - 1));
    assign release_grant = (state == GRANT) && (!owner_valid || (beat && last_beat));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            rr_ptr   <= rr_ptr_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    // A full FIFO only stalls the burst; release comes from the burst limit or a dropped valid.
    always_comb begin
        state_next    = state;
        grant_next    = grant;
        rr_ptr_next   = rr_ptr;
        beat_cnt_next = beat_cnt;
        unique case (state)
            IDLE: begin
                if (|eligible) begin
                    state_next    = GRANT;
                    grant_next    = pick;
                    beat_cnt_next = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    rr_ptr_next = (owner_idx == PW'(N - 1)) ? '0 : owner_idx + 1'b1;
                end else if (beat) begin
                    beat_cnt_next = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state == GRANT) begin
            busy         = 1'b1;
            req_ready    = fifo_full ? '0 : grant;
            fifo_wr_en   = beat;
            fifo_wr_data = owner_data;
        end
    end

    no_write_when_full: assert property (@(posedge clk) disable iff (reset)
        !(fifo_wr_en && fifo_full));

    grant_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant));

endmodule
